// File: rtl/dragon_segment_chain.sv
// Dragon body tracker: shifts {orient,pos} segments one cell per movement step and
// grows/shrinks on queued commands. Define SEG_COLLIDE_EN to build head-vs-body collision.
module dragon_segment_chain #(
    parameter int  SEG_MAX     = 16,
    parameter int  POS_W       = 8,
    parameter int  ORIEN_W     = 2,
    parameter int  MOVE_PERIOD = 20,
    parameter int  INIT_LEN    = 1,
    localparam int SEG_W       = ORIEN_W + POS_W,
    localparam int LEN_W       = $clog2(SEG_MAX + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     vsync,
    input  logic [1:0]               cmd,
    input  logic [SEG_W-1:0]         head_in,
    output logic [SEG_MAX*SEG_W-1:0] seg_bus,
    output logic [SEG_MAX-1:0]       seg_en,
    output logic [LEN_W-1:0]         length,
    output logic                     full,
    output logic                     step,
    output logic                     self_hit
);
    localparam int               FC_W     = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(MOVE_PERIOD - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(SEG_MAX);
    localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(INIT_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    logic              vsync_q;
    logic [FC_W-1:0]   frame_cnt;
    logic signed [3:0] delta;
    logic              vs_rise;
    logic              step_now;
    logic              do_grow;
    logic              do_shrink;
    logic              do_clear;
    logic [LEN_W-1:0]  len_next;
    logic signed [3:0] delta_adj;
    logic signed [3:0] delta_next;
    logic signed [4:0] delta_sum;

    assign vs_rise   = vsync & ~vsync_q;
    assign step_now  = vs_rise && (frame_cnt == FC_LAST);
    assign do_grow   = (cmd == 2'b01);
    assign do_shrink = (cmd == 2'b10);
    assign do_clear  = (cmd == 2'b11);

    function automatic logic [SEG_MAX-1:0] en_mask(input logic [LEN_W-1:0] len);
        logic [SEG_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < SEG_MAX; i++) begin
            m[i] = (i < int'(len));
        end
        return m;
    endfunction

    // The step consumes the old delta first; a coincident grow/shrink then counts toward the next step.
    always_comb begin
        len_next  = length;
        delta_adj = delta;
        if (do_clear) begin
            len_next  = LEN_INIT;
            delta_adj = 4'sd0;
        end else if (step_now) begin
            if (delta > 4'sd0) begin
                if (length < LEN_MAX) begin
                    len_next  = length + LEN_ONE;
                    delta_adj = delta - 4'sd1;
                end else begin
                    delta_adj = 4'sd0;
                end
            end else if (delta < 4'sd0) begin
                if (length > LEN_ONE) begin
                    len_next  = length - LEN_ONE;
                    delta_adj = delta + 4'sd1;
                end else begin
                    delta_adj = 4'sd0;
                end
            end
        end
        delta_sum = {delta_adj[3], delta_adj};
        if (do_grow) begin
            delta_sum = delta_sum + 5'sd1;
        end else if (do_shrink) begin
            delta_sum = delta_sum - 5'sd1;
        end
        if (delta_sum > 5'sd7) begin
            delta_next = 4'sd7;
        end else if (delta_sum < -5'sd7) begin
            delta_next = -4'sd7;
        end else begin
            delta_next = delta_sum[3:0];
        end
        if (do_clear) begin
            delta_next = 4'sd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_q   <= 1'b0;
            frame_cnt <= '0;
            delta     <= 4'sd0;
            length    <= LEN_INIT;
            seg_en    <= en_mask(LEN_INIT);
            full      <= (LEN_INIT == LEN_MAX);
            seg_bus   <= '0;
            step      <= 1'b0;
        end else begin
            vsync_q <= vsync;
            delta   <= delta_next;
            length  <= len_next;
            seg_en  <= en_mask(len_next);
            full    <= (len_next == LEN_MAX);
            step    <= step_now & ~do_clear;
            if (do_clear) begin
                seg_bus   <= '0;
                frame_cnt <= '0;
            end else begin
                if (vs_rise) begin
                    frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + 1'b1;
                end
                if (step_now) begin
                    seg_bus <= {seg_bus[(SEG_MAX-1)*SEG_W-1:0], head_in};
                end
            end
        end
    end

`ifdef SEG_COLLIDE_EN
    logic hit;

    // Only body cells that remain visible after the step can be hit; the tail cell moves away.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < SEG_MAX - 1; i++) begin
            if ((i + 1 < int'(len_next)) &&
                (seg_bus[i*SEG_W +: POS_W] == head_in[POS_W-1:0])) begin
                hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            self_hit <= 1'b0;
        end else begin
            self_hit <= step_now & ~do_clear & hit;
        end
    end
`else
    assign self_hit = 1'b0;
`endif

endmodule

// File: tb/tb_dragon_segment_chain.sv
// Directed bench for dragon_segment_chain: a behavioural body model pushes expected
// post-step snapshots to a queue that is popped whenever the DUT pulses step.
module tb_dragon_segment_chain;
    localparam int SEG_MAX     = 16;
    localparam int POS_W       = 8;
    localparam int ORIEN_W     = 2;
    localparam int SEG_W       = ORIEN_W + POS_W;
    localparam int MOVE_PERIOD = 4;
    localparam int INIT_LEN    = 1;
    localparam int LEN_W       = $clog2(SEG_MAX + 1);
    localparam int BUS_W       = SEG_MAX * SEG_W;
    localparam int REC_W       = LEN_W + 2 + BUS_W;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 vsync = 1'b0;
    logic [1:0]           cmd = 2'b00;
    logic [SEG_W-1:0]     head_in = '0;
    logic [BUS_W-1:0]     seg_bus;
    logic [SEG_MAX-1:0]   seg_en;
    logic [LEN_W-1:0]     length;
    logic                 full;
    logic                 step;
    logic                 self_hit;

    int n_checks = 0;
    int n_err    = 0;

    // model state
    int               m_len;
    int               m_delta;
    int               m_frame;
    logic [SEG_W-1:0] m_seg [SEG_MAX];
    logic [REC_W-1:0] exp_q [$];
    logic             last_hit;

`ifdef SEG_COLLIDE_EN
    localparam logic COLLIDE = 1'b1;
`else
    localparam logic COLLIDE = 1'b0;
`endif

    dragon_segment_chain #(
        .SEG_MAX(SEG_MAX), .POS_W(POS_W), .ORIEN_W(ORIEN_W),
        .MOVE_PERIOD(MOVE_PERIOD), .INIT_LEN(INIT_LEN)
    ) dut (
        .clk(clk), .reset(reset), .vsync(vsync), .cmd(cmd), .head_in(head_in),
        .seg_bus(seg_bus), .seg_en(seg_en), .length(length), .full(full),
        .step(step), .self_hit(self_hit)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [SEG_MAX-1:0] len_mask(input int len);
        return SEG_MAX'((1 << len) - 1);
    endfunction

    function automatic int sat7(input int v);
        return (v > 7) ? 7 : ((v < -7) ? -7 : v);
    endfunction

    task automatic model_reset();
        m_len = INIT_LEN;
        m_delta = 0;
        m_frame = 0;
        for (int i = 0; i < SEG_MAX; i++) m_seg[i] = '0;
    endtask

    task automatic model_cmd(input logic [1:0] c);
        if (c == 2'b01) m_delta = sat7(m_delta + 1);
        else if (c == 2'b10) m_delta = sat7(m_delta - 1);
        else if (c == 2'b11) model_reset();
    endtask

    task automatic model_step(input logic [SEG_W-1:0] head);
        logic             hit;
        logic [BUS_W-1:0] bus;
        if (m_delta > 0) begin
            if (m_len < SEG_MAX) begin m_len++; m_delta--; end
            else m_delta = 0;
        end else if (m_delta < 0) begin
            if (m_len > 1) begin m_len--; m_delta++; end
            else m_delta = 0;
        end
        hit = 1'b0;
        for (int i = 0; i < m_len - 1; i++)
            if (m_seg[i][POS_W-1:0] == head[POS_W-1:0]) hit = COLLIDE;
        for (int i = SEG_MAX - 1; i > 0; i--) m_seg[i] = m_seg[i-1];
        m_seg[0] = head;
        for (int i = 0; i < SEG_MAX; i++) bus[i*SEG_W +: SEG_W] = m_seg[i];
        exp_q.push_back({LEN_W'(m_len), (m_len == SEG_MAX), hit, bus});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] c, input int n);
        for (int k = 0; k < n; k++) begin
            cmd = c;
            tick();
            model_cmd(c);
        end
        cmd = 2'b00;
    endtask

    // One vsync pulse (high one clk, low one clk); c is held only in the rising cycle.
    task automatic vs_pulse(input logic [SEG_W-1:0] head, input logic [1:0] c);
        logic             exp_step;
        logic [REC_W-1:0] rec;
        logic [LEN_W-1:0] e_len;
        head_in = head;
        cmd = c;
        vsync = 1'b1;
        exp_step = (c != 2'b11) && (m_frame == MOVE_PERIOD - 1);
        if (c == 2'b11) begin
            model_cmd(c);
        end else begin
            if (m_frame == MOVE_PERIOD - 1) begin
                m_frame = 0;
                model_step(head);
            end else begin
                m_frame++;
            end
            model_cmd(c);
        end
        tick();
        cmd = 2'b00;
        vsync = 1'b0;
        chk("step_pulse", step, exp_step);
        if (step === 1'b1) begin
            last_hit = self_hit;
            if (exp_q.size() == 0) begin
                chk("queue_underflow", 1, 0);
            end else begin
                rec = exp_q.pop_front();
                e_len = rec[REC_W-1 -: LEN_W];
                chk("step_length", length, e_len);
                chk("step_seg_en", seg_en, len_mask(int'(e_len)));
                chk("step_full", full, rec[BUS_W+1]);
                chk("step_self_hit", self_hit, rec[BUS_W]);
                chk("step_seg_bus", seg_bus, rec[BUS_W-1:0]);
            end
            tick();
            chk("step_one_clk", step, 0);
            chk("self_hit_one_clk", self_hit, 0);
        end else begin
            chk("no_step_self_hit", self_hit, 0);
            tick();
        end
    endtask

    task automatic do_step(input logic [SEG_W-1:0] head);
        for (int k = 0; k < MOVE_PERIOD; k++) vs_pulse(head, 2'b00);
    endtask

    initial begin
        model_reset();
        last_hit = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg_bus", seg_bus, 0);
        chk("rst_length", length, 1);
        chk("rst_seg_en", seg_en, 16'h0001);
        chk("rst_full", full, 0);
        chk("rst_step", step, 0);
        chk("rst_self_hit", self_hit, 0);
        reset = 1'b1;
        tick();

        // no step on rises 1-3, step on the 4th
        do_step(10'h301);
        chk("t2_seg0", seg_bus[9:0], 10'h301);

        // shrink at length 1 is dropped, not remembered
        send_cmd(2'b10, 1);
        do_step(10'h0AA);
        chk("t5_len_floor", length, 1);
        send_cmd(2'b01, 1);
        do_step(10'h0BB);
        chk("t5_grow_after_drop", length, 2);

        send_cmd(2'b11, 1);
        chk("clr_length", length, 1);
        chk("clr_seg_bus", seg_bus, 0);

        for (int k = 1; k <= 3; k++) begin
            send_cmd(2'b01, 1);
            do_step(SEG_W'(k));
        end
        chk("t3_length", length, 4);
        chk("t3_seg_en", seg_en, 16'h000F);
        chk("t3_segs", seg_bus[39:0], {10'h000, 10'h001, 10'h002, 10'h003});

        // saturating delta, growth up to full, then drops
        send_cmd(2'b01, 20);
        for (int k = 0; k < 7; k++) do_step(SEG_W'($urandom_range(0, 1023)));
        chk("t4_len_after7", length, 11);
        send_cmd(2'b01, 20);
        for (int k = 0; k < 8; k++) do_step(SEG_W'($urandom_range(0, 1023)));
        chk("t4_len_full", length, 16);
        chk("t4_full", full, 1);
        send_cmd(2'b01, 3);
        do_step(SEG_W'($urandom_range(0, 1023)));
        chk("t4_grow_dropped", length, 16);
        chk("t4_seg_en_all", seg_en, 16'hFFFF);

        // clear coincident with a step: no shift
        for (int k = 0; k < MOVE_PERIOD - 1; k++) vs_pulse(10'h3C3, 2'b00);
        vs_pulse(10'h3C3, 2'b11);
        chk("t5_clr_step_len", length, 1);
        chk("t5_clr_step_bus", seg_bus, 0);
        chk("t5_clr_step_full", full, 0);

        // head lands on body segment 1 (orientation differs)
        send_cmd(2'b01, 1);
        do_step(10'h101);
        send_cmd(2'b01, 1);
        do_step(10'h145);
        send_cmd(2'b01, 1);
        do_step(10'h222);
        chk("t6_length", length, 4);
        chk("t6_seg1", seg_bus[19:10], 10'h145);
        do_step(10'h045);
        chk("t6_self_hit", last_hit, COLLIDE);

        // asynchronous reset mid-frame with growth pending
        send_cmd(2'b01, 2);
        vs_pulse(10'h111, 2'b00);
        vs_pulse(10'h111, 2'b00);
        #3;
        reset = 1'b0;
        #1;
        chk("mid_rst_seg_bus", seg_bus, 0);
        chk("mid_rst_length", length, 1);
        chk("mid_rst_seg_en", seg_en, 16'h0001);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_step", step, 0);
        tick();
        reset = 1'b1;
        model_reset();
        exp_q.delete();
        tick();
        do_step(10'h155);
        chk("post_rst_len", length, 1);
        chk("post_rst_seg0", seg_bus[9:0], 10'h155);

        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
